// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequences one byte-wide memory port between the program loader
// (single-byte writes) and instruction fetch (four byte reads -> 32-bit big-endian word).
// Latency: fetch -> instr_valid in cycle 6, write -> mem_wr in cycle 1, back in IDLE in cycle 2.
// Backpressure: instr_valid is held in HOLD until instr_ready; requests are only accepted in IDLE.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (rejects fetches with pc[1:0] != 0, pulses misalign).

module imem_fetch_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch side
    input  logic [31:0]       pc,
    input  logic              fetch_req,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              fetch_busy,
    // loader side
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    // memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [7:0]        r_mem_wdata;
    logic [31:0]       r_instr;
    logic              r_instr_valid;
    logic              r_fetch_busy;
`ifdef FETCH_MISALIGN_CHK_EN
    logic              r_misalign;
`endif

    logic              w_pc_misaligned;
    logic              w_unused_pc_hi;

    // Address bits above the memory size never reach the array.
    assign w_unused_pc_hi = ^pc[31:ADDR_W];

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_pc_misaligned = (pc[1:0] != 2'b00);
`else
    assign w_pc_misaligned = 1'b0;
`endif

    // Main sequencer: state, byte counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_mem_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_wdata   <= 8'd0;
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_fetch_busy  <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
            // strobes are single-cycle unless re-armed below
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (load_en) begin
                        // loader wins over fetch when both ask in the same cycle
                        r_mem_addr   <= load_addr;
                        r_mem_wdata  <= load_data;
                        r_mem_wr     <= 1'b1;
                        r_fetch_busy <= 1'b1;
                        r_state      <= S_WRITE;
                    end else if (fetch_req) begin
                        if (w_pc_misaligned) begin
`ifdef FETCH_MISALIGN_CHK_EN
                            r_misalign <= 1'b1;
`endif
                        end else begin
                            // first read goes out right away; mem_addr doubles as base+cnt
                            r_mem_addr   <= pc[ADDR_W-1:0];
                            r_mem_rd     <= 1'b1;
                            r_cnt        <= 2'd0;
                            r_fetch_busy <= 1'b1;
                            r_state      <= S_READ;
                        end
                    end
                end

                S_WRITE: begin
                    r_fetch_busy <= 1'b0;
                    r_state      <= S_IDLE;
                end

                S_READ: begin
                    // read data lags the strobe by one cycle, so nothing to capture at cnt 0
                    if (r_cnt != 2'd0) begin
                        r_instr <= {r_instr[23:0], mem_rdata};
                    end
                    if (r_cnt == 2'd3) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt      <= r_cnt + 2'd1;
                        r_mem_addr <= r_mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_mem_rd   <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    r_instr       <= {r_instr[23:0], mem_rdata};
                    r_instr_valid <= 1'b1;
                    r_state       <= S_HOLD;
                end

                S_HOLD: begin
                    if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_fetch_busy  <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end

                default: begin
                    r_fetch_busy  <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign load_ready  = (r_state == S_IDLE);
    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign mem_wdata   = r_mem_wdata;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fetch_busy  = r_fetch_busy;
`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign    = r_misalign;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: byte memory behind the port, transaction-level reference model,
// per-cycle compare on the falling edge, plus directed scenarios with literal expectations.
// Builds with or without FETCH_MISALIGN_CHK_EN.

module tb_imem_fetch_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pc = 32'd0;
    logic          fetch_req = 1'b0;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          fetch_busy;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    load_data = 8'd0;
    logic          load_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'd0;
`ifdef FETCH_MISALIGN_CHK_EN
    logic          misalign;
`endif

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc(pc), .fetch_req(fetch_req), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_busy(fetch_busy),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef FETCH_MISALIGN_CHK_EN
        , .misalign(misalign)
`endif
    );

    // Memory array seen by the DUT: synchronous write, one-cycle read.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model: one transaction at a time, timed from its sampling edge.
    // kind 0 idle, 1 write, 2 fetch, 3 rejected misaligned fetch (block stays idle)
    int         kind = 0;
    int         cyc = 0;
    int         t0 = 0;
    logic [7:0] ref_mem [256];
    logic [7:0] m_base = 8'd0;
    logic [7:0] m_la = 8'd0;
    logic [7:0] m_ld = 8'd0;
    logic [31:0] m_instr = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        int rel;
        logic [7:0] b1, b2, b3;
        if (!rst_n) begin
            kind = 0;
        end else begin
            rel = cyc - t0;
            if (kind == 1 && rel == 1) begin
                ref_mem[m_la] = m_ld;
                kind = 0;
            end else if (kind == 2 && rel >= 6 && instr_ready) begin
                kind = 0;
            end else if (kind == 0 || kind == 3) begin
                kind = 0;
                if (load_en) begin
                    kind = 1; t0 = cyc; m_la = load_addr; m_ld = load_data;
                end else if (fetch_req) begin
`ifdef FETCH_MISALIGN_CHK_EN
                    if (pc[1:0] != 2'b00) begin
                        kind = 3; t0 = cyc;
                    end else
`endif
                    begin
                        kind = 2; t0 = cyc; m_base = pc[7:0];
                        b1 = m_base + 8'd1; b2 = m_base + 8'd2; b3 = m_base + 8'd3;
                        m_instr = {ref_mem[m_base], ref_mem[b1], ref_mem[b2], ref_mem[b3]};
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    // Per-cycle compare against the model, mid-cycle.
    always @(negedge clk) begin
        int rel;
        logic e_rd, e_wr, e_valid, e_busy, e_mis;
        logic [7:0] e_addr;
        rel = cyc - t0;
        e_rd = 1'b0; e_wr = 1'b0; e_valid = 1'b0; e_busy = 1'b0; e_mis = 1'b0; e_addr = 8'd0;
        if (kind == 1) begin
            e_busy = 1'b1;
            if (rel == 1) begin e_wr = 1'b1; e_addr = m_la; end
        end else if (kind == 2) begin
            e_busy = 1'b1;
            if (rel >= 1 && rel <= 4) begin e_rd = 1'b1; e_addr = m_base + 8'(rel - 1); end
            if (rel >= 6) e_valid = 1'b1;
        end else if (kind == 3) begin
            if (rel == 1) e_mis = 1'b1;
        end
        chk("mem_rd", mem_rd, e_rd);
        chk("mem_wr", mem_wr, e_wr);
        chk("fetch_busy", fetch_busy, e_busy);
        chk("load_ready", load_ready, !e_busy);
        chk("instr_valid", instr_valid, e_valid);
        if (e_rd || e_wr) chk("mem_addr", mem_addr, e_addr);
        if (e_wr) chk("mem_wdata", mem_wdata, m_ld);
        if (e_valid) chk("instr", instr, m_instr);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("misalign", misalign, e_mis);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
        step();
    endtask

    // Issue a fetch, wait (bounded) for instr_valid, hold off acceptance for
    // hold_cyc cycles while pestering with ignored requests, then accept.
    task automatic fetch(input logic [31:0] p, input int hold_cyc, output int lat, output logic [31:0] got);
        fetch_req = 1'b1; pc = p;
        step();
        fetch_req = 1'b0;
        lat = 1;
        while (!instr_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("valid_within_budget", instr_valid, 1'b1);
        got = instr;
        for (int i = 0; i < hold_cyc; i++) begin
            fetch_req = 1'b1; load_en = 1'b1; load_addr = 8'h77; load_data = 8'hEE;
            step();
        end
        fetch_req = 1'b0; load_en = 1'b0;
        if (hold_cyc > 0) chk("hold_stable_instr", instr, got);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int r1, r2, n;
        logic seen;
        logic prev;
        logic [31:0] got;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'd0;
            ref_mem[i] = 8'd0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_ready", load_ready, 1'b1);
        chk("rst_fetch_busy", fetch_busy, 1'b0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        #2 rst_n = 1'b1;
        step();

        load_byte(8'h10, 8'h8C); load_byte(8'h11, 8'h22);
        load_byte(8'h12, 8'h00); load_byte(8'h13, 8'h04);
        load_byte(8'h14, 8'h55); load_byte(8'h15, 8'h66);
        load_byte(8'hFE, 8'h11); load_byte(8'hFF, 8'h22);
        load_byte(8'h00, 8'h33); load_byte(8'h01, 8'h44);

        // basic fetch with delayed acceptance and ignored requests in HOLD
        fetch(32'h10, 3, lat, got);
        chk("fetch_latency", lat, 6);
        chk("instr_8C220004", got, 32'h8C220004);
        chk("ignored_load", mem[8'h77], 8'h00);

        // simultaneous load + fetch: write first, fetch sampled at edge 2
        load_en = 1'b1; load_addr = 8'h20; load_data = 8'hAB; fetch_req = 1'b1; pc = 32'h10;
        step();
        chk("ld_ready_cycle1", load_ready, 1'b0);
        chk("ld_wr_cycle1", mem_wr, 1'b1);
        chk("ld_addr_cycle1", mem_addr, 32'h20);
        load_en = 1'b0;
        step();
        chk("ld_ready_cycle2", load_ready, 1'b1);
        step();
        fetch_req = 1'b0;
        chk("fetch_after_write_rd", mem_rd, 1'b1);
        n = 0;
        while (!instr_valid && n < 20) begin step(); n++; end
        chk("valid_after_write", instr_valid, 1'b1);
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        chk("written_byte", mem[8'h20], 8'hAB);

        // address wrap, upper pc bits ignored
        fetch(32'hABCD00FE, 0, lat, got);
        chk("wrap_instr", got, 32'h11223344);

        // misaligned pc
`ifdef FETCH_MISALIGN_CHK_EN
        fetch_req = 1'b1; pc = 32'h12;
        step();
        fetch_req = 1'b0;
        chk("misalign_pulse", misalign, 1'b1);
        chk("misalign_no_rd", mem_rd, 1'b0);
        chk("misalign_idle", load_ready, 1'b1);
        step();
        chk("misalign_one_cycle", misalign, 1'b0);
        chk("misalign_no_valid", instr_valid, 1'b0);
`else
        fetch(32'h12, 0, lat, got);
        chk("unaligned_instr", got, 32'h00045566);
`endif

        // reset during READ cycle 3
        fetch_req = 1'b1; pc = 32'h10;
        step();
        fetch_req = 1'b0;
        step(); step();
        chk("r3_rd", mem_rd, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", mem_rd, 1'b0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_busy", fetch_busy, 1'b0);
        chk("mid_rst_load_ready", load_ready, 1'b1);
        chk("mid_rst_instr", instr, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); seen = seen | instr_valid; end
        chk("no_valid_after_rst", seen, 1'b0);
        fetch(32'h10, 0, lat, got);
        chk("post_rst_instr", got, 32'h8C220004);

        // throughput with request and ready tied high
        fetch_req = 1'b1; pc = 32'h10; instr_ready = 1'b1;
        r1 = -1; r2 = -1; prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (instr_valid && !prev) begin
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            prev = instr_valid;
        end
        chk("throughput", r2 - r1, 7);
        fetch_req = 1'b0;
        n = 0;
        while (fetch_busy && n < 20) begin step(); n++; end
        chk("drain_idle", fetch_busy, 1'b0);
        instr_ready = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
